// File: rtl/pkt_rr_if.sv
// Stream bundle between N upstream sources, the arbiter and the packet queue.
// The master view belongs to the arbiter; the slave view belongs to the surrounding logic.
interface pkt_rr_if #(
    parameter int N_PORTS    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MTY_WIDTH  = 8
);
    logic [N_PORTS-1:0]            s_axis_tvalid;
    logic [N_PORTS*DATA_WIDTH-1:0] s_axis_tdata;
    logic [N_PORTS-1:0]            s_axis_tlast;
    logic [N_PORTS*MTY_WIDTH-1:0]  s_axis_tuser_mty;
    logic [N_PORTS-1:0]            s_axis_tready;

    logic                          m_axis_tvalid;
    logic [DATA_WIDTH-1:0]         m_axis_tdata;
    logic                          m_axis_tlast;
    logic [MTY_WIDTH-1:0]          m_axis_tuser_mty;
    logic                          m_axis_tready;

    logic                          drop_incmpt_pkt;

    modport master (
        input  s_axis_tvalid, s_axis_tdata, s_axis_tlast, s_axis_tuser_mty,
        output s_axis_tready,
        output m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser_mty,
        input  m_axis_tready,
        output drop_incmpt_pkt
    );

    modport slave (
        output s_axis_tvalid, s_axis_tdata, s_axis_tlast, s_axis_tuser_mty,
        input  s_axis_tready,
        input  m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser_mty,
        output m_axis_tready,
        input  drop_incmpt_pkt
    );
endinterface

// File: rtl/pkt_rr_arbiter.sv
// Packet-granular round-robin arbiter feeding one packet queue, with a per-packet
// stall watchdog that aborts a silent source and flushes the rest of its packet.
module pkt_rr_arbiter #(
    parameter int N_PORTS    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MTY_WIDTH  = 8,
    parameter int TIMEOUT    = 16
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    pkt_rr_if.master                   axis,
    output logic [$clog2(N_PORTS)-1:0] grant_idx,
    output logic [15:0]                abort_count
);
    localparam int IDX_W = $clog2(N_PORTS);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, BUSY, ABORT} state_t;

    state_t             state_q,       state_d;
    logic [IDX_W-1:0]   grant_q,       grant_d;
    logic [IDX_W-1:0]   last_grant_q,  last_grant_d;
    logic [CNT_W-1:0]   stall_cnt_q,   stall_cnt_d;
    logic [N_PORTS-1:0] flush_mask_q,  flush_mask_d;
    logic [15:0]        abort_count_q, abort_count_d;

    logic [N_PORTS-1:0] eligible;
    logic [N_PORTS-1:0] flush_done;
    logic               found;
    logic [IDX_W-1:0]   pick;

    logic [N_PORTS-1:0] s_tready;
    logic               m_tvalid;
    logic               drop;

    // A port still discarding an aborted packet may not compete for the queue.
    assign eligible   = axis.s_axis_tvalid & ~flush_mask_q;
    assign flush_done = flush_mask_q & axis.s_axis_tvalid & axis.s_axis_tlast;

    always_comb begin
        int idx;
        found = 1'b0;
        pick  = last_grant_q;
        idx   = 0;
        for (int k = 1; k <= N_PORTS; k++) begin
            idx = int'(last_grant_q) + k;
            if (idx >= N_PORTS) idx = idx - N_PORTS;
            if (!found && eligible[idx]) begin
                found = 1'b1;
                pick  = IDX_W'(idx);
            end
        end
    end

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned and infers a latch.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_grant_d  = last_grant_q;
        stall_cnt_d   = stall_cnt_q;
        flush_mask_d  = flush_mask_q & ~flush_done;
        abort_count_d = abort_count_q;
        s_tready      = flush_mask_q;
        m_tvalid      = 1'b0;
        drop          = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d     = pick;
                    stall_cnt_d = '0;
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                m_tvalid          = axis.s_axis_tvalid[grant_q];
                s_tready[grant_q] = axis.m_axis_tready;
                if (m_tvalid && axis.m_axis_tready && axis.s_axis_tlast[grant_q]) begin
                    last_grant_d = grant_q;
                    state_d      = IDLE;
                end
                // Only source silence counts; downstream back-pressure keeps tvalid high and resets the count.
                if (axis.s_axis_tvalid[grant_q]) begin
                    stall_cnt_d = '0;
                end else begin
                    stall_cnt_d = stall_cnt_q + 1'b1;
                    if (stall_cnt_q == CNT_W'(TIMEOUT - 1)) state_d = ABORT;
                end
            end
            ABORT: begin
                drop                  = 1'b1;
                flush_mask_d[grant_q] = 1'b1;
                last_grant_d          = grant_q;
                stall_cnt_d           = '0;
                if (abort_count_q != 16'hFFFF) abort_count_d = abort_count_q + 16'd1;
                state_d               = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q       <= IDLE;
            grant_q       <= IDX_W'(N_PORTS - 1);
            last_grant_q  <= IDX_W'(N_PORTS - 1);
            stall_cnt_q   <= '0;
            flush_mask_q  <= '0;
            abort_count_q <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_grant_q  <= last_grant_d;
            stall_cnt_q   <= stall_cnt_d;
            flush_mask_q  <= flush_mask_d;
            abort_count_q <= abort_count_d;
        end
    end

    assign axis.s_axis_tready    = s_tready;
    assign axis.m_axis_tvalid    = m_tvalid;
    assign axis.m_axis_tdata     = axis.s_axis_tdata[grant_q*DATA_WIDTH +: DATA_WIDTH];
    assign axis.m_axis_tlast     = axis.s_axis_tlast[grant_q];
    assign axis.m_axis_tuser_mty = axis.s_axis_tuser_mty[grant_q*MTY_WIDTH +: MTY_WIDTH];
    assign axis.drop_incmpt_pkt  = drop;
    assign grant_idx             = grant_q;
    assign abort_count           = abort_count_q;
endmodule

// File: tb/tb_pkt_rr_arbiter.sv
// Directed bench for pkt_rr_arbiter: queue-backed sources, an output monitor and
// hand-computed expected beat sequences.
module tb_pkt_rr_arbiter;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MW = 8;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic aresetn;
    logic [1:0]  grant_idx;
    logic [15:0] abort_count;

    always #5 clk = ~clk;

    pkt_rr_if #(.N_PORTS(N), .DATA_WIDTH(DW), .MTY_WIDTH(MW)) bus ();

    pkt_rr_arbiter #(.N_PORTS(N), .DATA_WIDTH(DW), .MTY_WIDTH(MW), .TIMEOUT(TO)) dut (
        .aclk        (clk),
        .aresetn     (aresetn),
        .axis        (bus),
        .grant_idx   (grant_idx),
        .abort_count (abort_count)
    );

    typedef struct packed {
        logic [7:0] data;
        logic [7:0] mty;
        logic       last;
    } beat_t;

    typedef struct {
        logic [31:0] word;
        int          cyc;
    } obs_t;

    beat_t       src_q [N][$];
    obs_t        out_q [$];
    logic [31:0] exp_q [$];

    int errors      = 0;
    int checks      = 0;
    int cyc         = 0;
    int drop_cnt    = 0;
    int overlap_cnt = 0;
    int bp_violate  = 0;
    bit bp_watch    = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] mk_word(input int port, input logic [7:0] d,
                                            input logic [7:0] m, input logic l);
        return {8'(port), 7'd0, l, m, d};
    endfunction

    function automatic int pending();
        int s = 0;
        for (int i = 0; i < N; i++) s += src_q[i].size();
        return s;
    endfunction

    task automatic drive();
        logic [N-1:0]    v, l;
        logic [N*DW-1:0] d;
        logic [N*MW-1:0] m;
        beat_t           b;
        v = '0; l = '0; d = '0; m = '0;
        for (int i = 0; i < N; i++) begin
            if (src_q[i].size() > 0) begin
                b            = src_q[i][0];
                v[i]         = 1'b1;
                l[i]         = b.last;
                d[i*DW +: DW] = b.data;
                m[i*MW +: MW] = b.mty;
            end
        end
        bus.s_axis_tvalid    = v;
        bus.s_axis_tlast     = l;
        bus.s_axis_tdata     = d;
        bus.s_axis_tuser_mty = m;
    endtask

    // Sample on the falling edge, let the rising edge happen, then advance the sources.
    task automatic tick();
        bit    pop [N];
        obs_t  o;
        beat_t tmp;
        @(negedge clk);
        for (int i = 0; i < N; i++) pop[i] = bus.s_axis_tvalid[i] && bus.s_axis_tready[i];
        if (bus.m_axis_tvalid && bus.m_axis_tready) begin
            o.word = mk_word(int'(grant_idx), bus.m_axis_tdata, bus.m_axis_tuser_mty, bus.m_axis_tlast);
            o.cyc  = cyc;
            out_q.push_back(o);
        end
        if (bus.drop_incmpt_pkt) drop_cnt++;
        if (bus.drop_incmpt_pkt && bus.m_axis_tvalid) overlap_cnt++;
        if (bp_watch && bus.s_axis_tready[1]) bp_violate++;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) if (pop[i] && src_q[i].size() > 0) tmp = src_q[i].pop_front();
        cyc++;
        drive();
    endtask

    task automatic push_pkt(input int port, input int len, input int base,
                            input logic [7:0] last_mty, input bit with_last, input bit to_exp);
        beat_t x;
        for (int b = 0; b < len; b++) begin
            x.data = 8'(base + b);
            x.last = with_last && (b == len - 1);
            x.mty  = x.last ? last_mty : 8'h00;
            src_q[port].push_back(x);
            if (to_exp) exp_q.push_back(mk_word(port, x.data, x.mty, x.last));
        end
    endtask

    task automatic drain(input string name, input int max_cycles);
        int n = 0;
        while (pending() > 0 && n < max_cycles) begin
            tick();
            n++;
        end
        check({name, "_drain"}, pending(), 0);
    endtask

    task automatic compare_out(input string name);
        int n;
        check({name, "_beats"}, out_q.size(), exp_q.size());
        n = (out_q.size() < exp_q.size()) ? out_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check($sformatf("%s_beat%0d", name, i), out_q[i].word, exp_q[i]);
    endtask

    task automatic reset_dut();
        aresetn           = 1'b0;
        bus.m_axis_tready = 1'b0;
        for (int i = 0; i < N; i++) src_q[i].delete();
        drive();
        tick();
        tick();
        aresetn           = 1'b1;
        bus.m_axis_tready = 1'b1;
        out_q.delete();
        exp_q.delete();
        drop_cnt = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int    n;
        int    gap;
        logic [31:0] tmpw;

        aresetn           = 1'b0;
        bus.m_axis_tready = 1'b0;
        drive();

        // Reset state
        reset_dut();
        #1;
        check("rst_m_tvalid", bus.m_axis_tvalid, 0);
        check("rst_s_tready", bus.s_axis_tready, 0);
        check("rst_drop", bus.drop_incmpt_pkt, 0);
        check("rst_abort_count", abort_count, 0);
        check("rst_grant_idx", grant_idx, 3);

        // Two 13-beat packets: port 0 first, one bubble, then port 2
        reset_dut();
        push_pkt(0, 13, 0, 8'h01, 1, 1);
        push_pkt(2, 13, 0, 8'h02, 1, 1);
        drive();
        drain("t1", 60);
        repeat (2) tick();
        compare_out("t1");
        gap = (out_q.size() >= 14) ? out_q[13].cyc - out_q[12].cyc : -1;
        check("t1_bubble", gap, 2);

        // All four ports busy with 3-beat packets: strict rotation, 4 cycles per packet
        reset_dut();
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < N; i++) push_pkt(i, 3, i*16 + p*4, 8'(i), 1, 1);
        drive();
        drain("t2", 80);
        repeat (2) tick();
        compare_out("t2");
        gap = (out_q.size() >= 24) ? out_q[23].cyc - out_q[0].cyc : -1;
        check("t2_span", gap, 30);

        // Long downstream back-pressure mid-packet must not abort
        reset_dut();
        push_pkt(1, 6, 8'h40, 8'h05, 1, 1);
        drive();
        n = 0;
        while (out_q.size() < 2 && n < 20) begin tick(); n++; end
        bus.m_axis_tready = 1'b0;
        bp_violate = 0;
        bp_watch   = 1'b1;
        repeat (40) tick();
        bp_watch = 1'b0;
        check("t3_tready_low", bp_violate, 0);
        check("t3_no_drop", drop_cnt, 0);
        check("t3_held_beats", out_q.size(), 2);
        bus.m_axis_tready = 1'b1;
        drain("t3", 20);
        repeat (2) tick();
        compare_out("t3");
        check("t3_abort_count", abort_count, 0);

        // Port 3 goes silent after 5 beats: abort, flush 8 beats, then re-grant
        reset_dut();
        push_pkt(3, 5, 8'h00, 8'h00, 0, 1);
        drive();
        drain("t4_head", 20);
        repeat (TO) tick();
        check("t4_no_early_drop", drop_cnt, 0);
        tick();
        check("t4_drop", drop_cnt, 1);
        check("t4_abort_count", abort_count, 1);
        repeat (3) tick();
        check("t4_drop_width", drop_cnt, 1);
        push_pkt(3, 8, 8'h10, 8'h04, 1, 0);
        drive();
        drain("t4_flush", 20);
        check("t4_flush_not_fwd", out_q.size(), 5);
        push_pkt(3, 2, 8'h20, 8'h03, 1, 1);
        drive();
        drain("t4_regrant", 20);
        repeat (2) tick();
        compare_out("t4");

        // Port 0 aborts while port 1 waits; flush and forwarding overlap
        reset_dut();
        push_pkt(0, 3, 8'h50, 8'h00, 0, 1);
        push_pkt(1, 4, 8'h60, 8'h06, 1, 1);
        drive();
        n = 0;
        while (drop_cnt == 0 && n < 40) begin tick(); n++; end
        check("t5_abort", drop_cnt, 1);
        push_pkt(0, 4, 8'h70, 8'h09, 1, 0);
        drive();
        repeat (5) tick();
        check("t5_concurrent", pending(), 0);
        repeat (2) tick();
        compare_out("t5");
        check("t5_abort_count", abort_count, 1);

        // One-cycle reset in the middle of port 2's packet
        out_q.delete();
        exp_q.delete();
        check("t6_pre_abort_count", abort_count, 1);
        push_pkt(2, 10, 8'h80, 8'h07, 1, 1);
        push_pkt(3, 2, 8'h90, 8'h08, 1, 1);
        drive();
        n = 0;
        while (out_q.size() < 3 && n < 20) begin tick(); n++; end
        check("t6_pre_beats", out_q.size(), 3);
        for (int i = 0; i < 3; i++) begin
            tmpw = exp_q.pop_front();
            if (i < out_q.size()) check($sformatf("t6_pre_beat%0d", i), out_q[i].word, tmpw);
        end
        aresetn           = 1'b0;
        bus.m_axis_tready = 1'b0;
        tick();
        aresetn           = 1'b1;
        bus.m_axis_tready = 1'b1;
        #1;
        check("t6_s_tready", bus.s_axis_tready, 0);
        check("t6_m_tvalid", bus.m_axis_tvalid, 0);
        check("t6_drop", bus.drop_incmpt_pkt, 0);
        check("t6_abort_count", abort_count, 0);
        check("t6_grant_idx", grant_idx, 3);
        out_q.delete();
        drain("t6", 40);
        repeat (2) tick();
        compare_out("t6");

        check("drop_vs_tvalid", overlap_cnt, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
